fs_serial: RTL and testbench



---
 rtl/fs_pkg.sv | 22 ++
 rtl/fs_bit_cell.sv | 16 +
 rtl/fs_serial.sv | 97 +++++++++
 tb/tb_fs_serial.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared definitions for the subtractor family: FSM state encoding and the
// one-bit full-subtractor equations, so parallel and serial subtractors use
// identical borrow logic.
package fs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fs_state_t;

    // Difference bit of x - y - c.
    function automatic logic diff_bit(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Borrow out of x - y - c: needed whenever y + c exceeds x.
    function automatic logic borrow_bit(input logic x, input logic y, input logic c);
        return (~x & y) | (~x & c) | (y & c);
    endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational one-bit full subtractor; the serial datapath feeds it one
// operand bit and the stored borrow per clock.
module fs_bit_cell
    import fs_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic dif,
    output logic bo
);

    assign dif = diff_bit(x, y, bi);
    assign bo  = borrow_bit(x, y, bi);

endmodule

// File: rtl/fs_serial.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one bit per clock with a
// single borrow flip-flop. Operands are captured on an accepted start, the
// result is shifted into sd and published to d/bout only when the operation
// completes, so the outputs hold the previous result during a new run.
module fs_serial
    import fs_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bout
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    fs_state_t     state;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [W-1:0]  sd;
    logic          br;
    logic [CW-1:0] cnt;

    logic          cell_dif;
    logic          cell_bo;

    // The single shared bit cell works on the current LSBs and stored borrow.
    fs_bit_cell u_cell (
        .x   (sa[0]),
        .y   (sb[0]),
        .bi  (br),
        .dif (cell_dif),
        .bo  (cell_bo)
    );

    // Control FSM plus datapath registers; DONE also accepts start so
    // operations can run back-to-back with no idle cycle between them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        sd    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    br <= cell_bo;
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    sd <= {cell_dif, sd[W-1:1]};
                    if (cnt == LAST) begin
                        d     <= {cell_dif, sd[W-1:1]};
                        bout  <= cell_bo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fs_serial.sv
// Self-checking bench for fs_serial: expected results are queued when an
// operation is launched and compared whenever the DUT pulses done.
module tb_fs_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    typedef struct packed {
        logic         bout;
        logic [W-1:0] d;
    } result_t;

    result_t expQ[$];
    int      vectors     = 0;
    int      miscompares = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    fs_serial #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic result_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                      input logic mbin);
        logic [W:0] r;
        r = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        return r;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] na, input logic [W-1:0] nb,
                                 input logic nbin, input bit expectResult);
        a     = na;
        b     = nb;
        bin   = nbin;
        start = 1'b1;
        if (expectResult) expQ.push_back(model(na, nb, nbin));
    endtask

    // Scoreboard: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        result_t e;
        if (done === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", 32'(1), 32'(0));
            end else begin
                e = expQ.pop_front();
                checkOutput("d", 32'(d), 32'(e.d));
                checkOutput("bout", 32'(bout), 32'(e.bout));
            end
        end
    end

    // One start pulse, then measure latency, busy length and output hold.
    task automatic runOp(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nbin);
        logic [W-1:0] prevD;
        int           busyCycles = 0;
        int           latency    = 0;
        bit           holdBad    = 1'b0;
        bit           sawDone    = 1'b0;
        prevD = d;
        applyStimulus(na, nb, nbin, 1'b1);
        repeat (W + 4) begin
            @(negedge clk);
            start = 1'b0;
            latency++;
            if (busy) begin
                busyCycles++;
                if (d !== prevD) holdBad = 1'b1;
            end
            if (done) begin
                sawDone = 1'b1;
                break;
            end
        end
        checkOutput("sawDone", 32'(sawDone), 32'(1));
        checkOutput("latency", 32'(latency), 32'(W + 1));
        checkOutput("busyCycles", 32'(busyCycles), 32'(W));
        checkOutput("holdD", 32'(holdBad), 32'(0));
    endtask

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  gap;
        bit  sawDone;
        bit  holdBad;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 32'(0));
        checkOutput("rstDone", 32'(done), 32'(0));
        checkOutput("rstD", 32'(d), 32'(0));
        checkOutput("rstBout", 32'(bout), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases including borrow-in extremes.
        runOp(4'b1001, 4'b0010, 1'b0);
        runOp(4'b0010, 4'b1001, 1'b0);
        runOp(4'b0000, 4'b0000, 1'b1);
        runOp(4'b1111, 4'b1111, 1'b1);
        @(negedge clk);

        // Back-to-back with start held high; second operands applied in DONE.
        applyStimulus(4'b0110, 4'b0011, 1'b1, 1'b1);
        sawDone = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) begin
                sawDone = 1'b1;
                break;
            end
        end
        checkOutput("b2bFirstDone", 32'(sawDone), 32'(1));
        applyStimulus(4'b1100, 4'b0110, 1'b0, 1'b1);
        gap     = 0;
        sawDone = 1'b0;
        holdBad = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            start = 1'b0;
            gap++;
            if (busy && d !== 4'b0010) holdBad = 1'b1;
            if (done) begin
                sawDone = 1'b1;
                break;
            end
        end
        checkOutput("b2bSecondDone", 32'(sawDone), 32'(1));
        checkOutput("b2bGap", 32'(gap), 32'(W + 1));
        checkOutput("b2bHoldD", 32'(holdBad), 32'(0));
        @(negedge clk);

        // Start re-pulsed with new operands during RUN must be ignored.
        applyStimulus(4'b1011, 4'b0001, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        applyStimulus(4'b0101, 4'b0100, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        a     = 4'b1110;
        b     = 4'b0111;
        sawDone = 1'b0;
        repeat (W + 4) begin
            if (done) begin
                sawDone = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("ignoreDone", 32'(sawDone), 32'(1));
        @(negedge clk);
        checkOutput("ignoreIdle", 32'(busy), 32'(0));

        // Abort two cycles into RUN: no done, outputs cleared.
        applyStimulus(4'b1011, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("abortStarted", 32'(busy), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortBusy", 32'(busy), 32'(0));
        checkOutput("abortDone", 32'(done), 32'(0));
        checkOutput("abortD", 32'(d), 32'(0));
        checkOutput("abortBout", 32'(bout), 32'(0));
        rst = 1'b0;
        sawDone = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("abortNoDone", 32'(sawDone), 32'(0));

        // Reset and start together: reset wins.
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rstStartBusy", 32'(busy), 32'(0));
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("rstStartIdle", 32'(busy), 32'(0));

        // Random operands.
        for (int i = 0; i < 8; i++) begin
            runOp(W'($urandom_range(2 ** W - 1)), W'($urandom_range(2 ** W - 1)),
                  1'($urandom_range(1)));
        end

        repeat (2) @(negedge clk);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
